// File: rtl/codec_cfg_pkg.sv
// Shared types and the power-up register table for the codec configuration sequencer.
// Table entries are {reg[6:0], data[8:0]}. The last entry must be the ACTIVE write.
package codec_cfg_pkg;

  localparam int REG_W   = 7;
  localparam int VAL_W   = 9;
  localparam int ENTRY_W = REG_W + VAL_W;

  typedef logic [ENTRY_W-1:0] entry_t;

  localparam logic [REG_W-1:0] LINVOL   = 7'h00;
  localparam logic [REG_W-1:0] RINVOL   = 7'h01;
  localparam logic [REG_W-1:0] LHPVOL   = 7'h02;
  localparam logic [REG_W-1:0] RHPVOL   = 7'h03;
  localparam logic [REG_W-1:0] ANAPATH  = 7'h04;
  localparam logic [REG_W-1:0] DIGPATH  = 7'h05;
  localparam logic [REG_W-1:0] PWRDN    = 7'h06;
  localparam logic [REG_W-1:0] DAIF     = 7'h07;
  localparam logic [REG_W-1:0] SAMPLING = 7'h08;
  localparam logic [REG_W-1:0] ACTIVE   = 7'h09;
  localparam logic [REG_W-1:0] RESET    = 7'h0F;

  localparam int CFG_LEN   = 11;
  localparam int CFG_IDX_W = $clog2(CFG_LEN);

  localparam entry_t CFG_TABLE [CFG_LEN] = '{
    {RESET,    9'h000},
    {LINVOL,   9'h017},
    {RINVOL,   9'h017},
    {LHPVOL,   9'h079},
    {RHPVOL,   9'h079},
    {ANAPATH,  9'h012},
    {DIGPATH,  9'h000},
    {PWRDN,    9'h000},
    {DAIF,     9'h002},
    {SAMPLING, 9'h000},
    {ACTIVE,   9'h001}
  };

  typedef enum logic [3:0] {
    IDLE, RST_HOLD, PWR_WAIT, LOAD, WRITE, NEXT, ACT_WAIT, DONE, ERR, HOST_WR
  } seq_state_t;

  typedef enum logic [2:0] {
    WR_IDLE, BYTE0, BYTE1, BYTE2, WAIT_RSP
  } wr_state_t;

  function automatic entry_t cfg_entry(input int unsigned i);
    return (i < CFG_LEN) ? CFG_TABLE[i[CFG_IDX_W-1:0]] : '0;
  endfunction

endpackage

// File: rtl/codec_reg_wr.sv
// Three-byte I2C register write engine: address byte with START, {reg,d8}, d[7:0] with STOP.
// Retries the whole transaction from the address byte on any NACK.
module codec_reg_wr
  import codec_cfg_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         WR_RETRIES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  entry_t     word,
  output logic       busy,
  output logic       ok,
  output logic       fail,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_start,
  output logic       cmd_stop,
  output logic [7:0] cmd_data,
  input  logic       rsp_valid,
  input  logic       rsp_nack
);

  localparam int RTY_W = (WR_RETRIES < 1) ? 1 : $clog2(WR_RETRIES + 1);

  wr_state_t        state, state_nxt;
  entry_t           word_q;
  logic [1:0]       phase, phase_nxt;
  logic [RTY_W-1:0] retry, retry_nxt;
  logic             ok_nxt, fail_nxt;
  logic             enter_byte;

  function automatic logic [7:0] byte_of(input logic [1:0] p, input entry_t w);
    case (p)
      2'd0:    return {DEV_ADDR, 1'b0};
      2'd1:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    retry_nxt = retry;
    ok_nxt    = 1'b0;
    fail_nxt  = 1'b0;
    unique case (state)
      WR_IDLE: if (go) begin
        state_nxt = BYTE0;
        phase_nxt = 2'd0;
        retry_nxt = '0;
      end
      BYTE0, BYTE1, BYTE2: if (cmd_valid && cmd_ready) state_nxt = WAIT_RSP;
      WAIT_RSP: if (rsp_valid) begin
        if (rsp_nack) begin
          if (int'(retry) < WR_RETRIES) begin
            retry_nxt = retry + 1'b1;
            phase_nxt = 2'd0;
            state_nxt = BYTE0;
          end else begin
            fail_nxt  = 1'b1;
            state_nxt = WR_IDLE;
          end
        end else if (phase == 2'd2) begin
          ok_nxt    = 1'b1;
          state_nxt = WR_IDLE;
        end else begin
          phase_nxt = phase + 1'b1;
          state_nxt = (phase == 2'd0) ? BYTE1 : BYTE2;
        end
      end
      default: state_nxt = WR_IDLE;
    endcase
  end

  // Command fields only change when a new byte is presented, so they stay put under backpressure.
  assign enter_byte = (state_nxt inside {BYTE0, BYTE1, BYTE2}) && (state_nxt != state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WR_IDLE;
      phase     <= 2'd0;
      retry     <= '0;
      ok        <= 1'b0;
      fail      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_start <= 1'b0;
      cmd_stop  <= 1'b0;
      cmd_data  <= 8'h00;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      retry     <= retry_nxt;
      ok        <= ok_nxt;
      fail      <= fail_nxt;
      cmd_valid <= state_nxt inside {BYTE0, BYTE1, BYTE2};
      if (enter_byte) begin
        cmd_start <= (state_nxt == BYTE0);
        cmd_stop  <= (state_nxt == BYTE2);
        cmd_data  <= byte_of(phase_nxt, word_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == WR_IDLE && go) word_q <= word;
  end

  assign busy = (state != WR_IDLE);

endmodule

// File: rtl/codec_cfg_seq.sv
// Codec power-up sequencer: hardware reset, power-up wait, table write, ACTIVE delay, done.
// Optional CODEC_CFG_HOSTWR_EN adds a host single-register write port usable once in DONE.
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR        = 7'h1A,
  parameter int         NUM_REGS        = 11,
  parameter int         RST_CYCLES      = 1000,
  parameter int         PWR_WAIT_CYCLES = 50000,
  parameter int         ACT_WAIT_CYCLES = 10000,
  parameter int         WR_RETRIES      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        codec_rstn,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_start,
  output logic        cmd_stop,
  output logic [7:0]  cmd_data,
  input  logic        rsp_valid,
  input  logic        rsp_nack
`ifdef CODEC_CFG_HOSTWR_EN
  ,
  input  logic        host_wr_valid,
  output logic        host_wr_ready,
  input  logic [15:0] host_wr_word
`endif
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_WAIT = max2(max2(max2(RST_CYCLES, PWR_WAIT_CYCLES), ACT_WAIT_CYCLES), 2);
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam int IDX_W    = $clog2(NUM_REGS + 1);

  // A wait of N cycles loads N-1 and leaves on zero; 0 and 1 both give one cycle.
  function automatic logic [CNT_W-1:0] reload(input int n);
    return (n <= 1) ? '0 : CNT_W'(n - 1);
  endfunction

  localparam logic [CNT_W-1:0] RST_LD = reload(RST_CYCLES);
  localparam logic [CNT_W-1:0] PWR_LD = reload(PWR_WAIT_CYCLES);
  localparam logic [CNT_W-1:0] ACT_LD = reload(ACT_WAIT_CYCLES);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             go, wr_busy, wr_ok, wr_fail, busy_q;
  entry_t           word;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? '0 : cnt - 1'b1;
    idx_nxt   = idx;
    go        = 1'b0;
    word      = cfg_entry(32'(idx));
`ifdef CODEC_CFG_HOSTWR_EN
    host_wr_ready = 1'b0;
`endif
    unique case (state)
      IDLE, ERR: if (start) begin
        state_nxt = RST_HOLD;
        cnt_nxt   = RST_LD;
      end
      DONE: begin
        if (start) begin
          state_nxt = RST_HOLD;
          cnt_nxt   = RST_LD;
        end
`ifdef CODEC_CFG_HOSTWR_EN
        else begin
          host_wr_ready = 1'b1;
          if (host_wr_valid) begin
            go        = 1'b1;
            word      = host_wr_word;
            state_nxt = HOST_WR;
          end
        end
`endif
      end
      RST_HOLD: if (cnt == '0) begin
        state_nxt = PWR_WAIT;
        cnt_nxt   = PWR_LD;
      end
      PWR_WAIT: if (cnt == '0) begin
        state_nxt = LOAD;
        idx_nxt   = '0;
      end
      LOAD: begin
        go        = 1'b1;
        state_nxt = WRITE;
      end
      WRITE, HOST_WR: begin
        if (wr_fail)    state_nxt = ERR;
        else if (wr_ok) state_nxt = (state == WRITE) ? NEXT : DONE;
      end
      NEXT: begin
        idx_nxt = idx + 1'b1;
        if (int'(idx) + 1 >= NUM_REGS) begin
          state_nxt = DONE;
        end else if (int'(idx) + 1 == NUM_REGS - 1) begin
          state_nxt = ACT_WAIT;
          cnt_nxt   = ACT_LD;
        end else begin
          state_nxt = LOAD;
        end
      end
      ACT_WAIT: if (cnt == '0) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change with it, glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      busy_q     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      codec_rstn <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      busy_q     <= !(state_nxt inside {IDLE, DONE, ERR});
      done       <= state_nxt inside {DONE, HOST_WR};
      err        <= (state_nxt == ERR);
      codec_rstn <= !(state_nxt inside {IDLE, RST_HOLD});
    end
  end

  assign busy = busy_q | wr_busy;

  codec_reg_wr #(
    .DEV_ADDR  (DEV_ADDR),
    .WR_RETRIES(WR_RETRIES)
  ) u_wr (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .word     (word),
    .busy     (wr_busy),
    .ok       (wr_ok),
    .fail     (wr_fail),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_start(cmd_start),
    .cmd_stop (cmd_stop),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_nack (rsp_nack)
  );

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Directed bench for codec_cfg_seq: an I2C byte-master responder plus an expected byte-stream model.
`timescale 1ns/1ps
module tb_codec_cfg_seq;

  localparam int         RSTC = 4;
  localparam int         PWRC = 8;
  localparam int         ACTC = 5;
  localparam int         RETR = 3;
  localparam int         NREG = 11;
  localparam logic [6:0] DEVA = 7'h1A;
  localparam int         BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, err, codec_rstn;
  logic       cmd_valid, cmd_start, cmd_stop;
  logic       cmd_ready = 1'b0;
  logic [7:0] cmd_data;
  logic       rsp_valid = 1'b0;
  logic       rsp_nack = 1'b0;
`ifdef CODEC_CFG_HOSTWR_EN
  logic        host_wr_valid = 1'b0;
  logic        host_wr_ready;
  logic [15:0] host_wr_word = 16'h0000;
`endif

  int checks = 0;
  int failures = 0;

  // Register table as the codec datasheet values {reg, data}, written out by hand.
  logic [15:0] cfg_words [NREG] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                    16'h0812, 16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};

  logic [9:0] exp_q[$];
  logic [9:0] log_q[$];
  int   mode = 0, ready_delay = 0, entries_done = 0, nack_cnt = 0, bytes_seen = 0;
  logic hold_flag = 1'b0, release_flag = 1'b0, stray_done = 1'b0;

  always #5 clk = ~clk;

  codec_cfg_seq #(
    .DEV_ADDR(DEVA), .NUM_REGS(NREG), .RST_CYCLES(RSTC),
    .PWR_WAIT_CYCLES(PWRC), .ACT_WAIT_CYCLES(ACTC), .WR_RETRIES(RETR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .codec_rstn(codec_rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack)
`ifdef CODEC_CFG_HOSTWR_EN
    , .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_word(host_wr_word)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_write(input logic [15:0] w, input int nack_b1_times);
    for (int k = 0; k < nack_b1_times; k++) begin
      exp_q.push_back({2'b10, DEVA, 1'b0});
      exp_q.push_back({2'b00, w[15:8]});
    end
    exp_q.push_back({2'b10, DEVA, 1'b0});
    exp_q.push_back({2'b00, w[15:8]});
    exp_q.push_back({2'b01, w[7:0]});
  endtask

  // Expected command stream: each byte is {start, stop, data}.
  task automatic build_expected(input int m);
    exp_q.delete();
    if (m == 2) begin
      for (int k = 0; k <= RETR; k++) exp_q.push_back({2'b10, DEVA, 1'b0});
    end else begin
      for (int e = 0; e < NREG; e++) push_write(cfg_words[e], (m == 1 && e == 2) ? 2 : 0);
    end
  endtask

  task automatic prep(input int m, input int d);
    mode = m; ready_delay = d; entries_done = 0; nack_cnt = 0; bytes_seen = 0;
    log_q.delete();
    build_expected(m);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_rstn_low(input string name);
    int n = 0;
    while (!codec_rstn && n < 50) begin
      n++;
      @(negedge clk);
    end
    check(name, n, RSTC);
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(done || err) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      checks++; failures++;
      $display("FAIL %s: no done/err within %0d cycles", name, BUDGET);
    end
  endtask

  // I2C master responder; it also compares every accepted byte against the expected stream.
  initial begin
    logic [9:0] s;
    logic       nack;
    forever begin
      @(negedge clk);
      if (cmd_valid && !rst) begin
        s = {cmd_start, cmd_stop, cmd_data};
        for (int i = 0; i < ready_delay; i++) begin
          @(negedge clk);
          check("bp_stable", {cmd_valid, cmd_start, cmd_stop, cmd_data}, {1'b1, s});
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("valid_drop", cmd_valid, 1'b0);
        log_q.push_back(s);
        bytes_seen++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL byte_extra: got %0h expected none", s);
        end else begin
          check("byte", s, exp_q.pop_front());
        end
        nack = 1'b0;
        if (mode == 1 && !s[9] && !s[8] && entries_done == 2 && nack_cnt < 2) begin
          nack = 1'b1;
          nack_cnt++;
        end
        if (mode == 2 && s[9]) nack = 1'b1;
        if (mode == 3 && entries_done == 5 && s[9]) begin
          hold_flag = 1'b1;
          while (!release_flag) @(negedge clk);
          @(negedge clk);
          rsp_valid = 1'b1; rsp_nack = 1'b0;
          @(negedge clk);
          rsp_valid = 1'b0;
          stray_done = 1'b1;
        end else begin
          @(negedge clk);
          rsp_valid = 1'b1; rsp_nack = nack;
          @(negedge clk);
          rsp_valid = 1'b0; rsp_nack = 1'b0;
          if (!nack && s[8]) entries_done++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("done_err_excl", done && err, 1'b0);
      if (err) check("err_not_busy", busy, 1'b0);
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rstn", codec_rstn, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_start", cmd_start, 0);
    check("rst_stop", cmd_stop, 0);
    check("rst_data", cmd_data, 0);

    // Clean sequence
    prep(0, 0);
    check("model_b0", exp_q[0], 10'h234);
    check("model_b1", exp_q[1], 10'h01E);
    check("model_b2", exp_q[2], 10'h100);
    pulse_start();
    check("busy_after_start", busy, 1);
    check_rstn_low("clean_rstn_low");
    wait_end("clean");
    check("clean_done", done, 1);
    check("clean_err", err, 0);
    check("clean_busy", busy, 0);
    check("clean_bytes", bytes_seen, 33);
    check("clean_left", exp_q.size(), 0);
    check("clean_log0", log_q[0], {2'b10, 8'h34});
    check("clean_log1", log_q[1], {2'b00, 8'h1E});
    check("clean_log2", log_q[2], {2'b01, 8'h00});

    // Backpressure, restarted from DONE
    prep(0, 7);
    pulse_start();
    check("bp_done_cleared", done, 0);
    check_rstn_low("bp_rstn_low");
    wait_end("bp");
    check("bp_done", done, 1);
    check("bp_bytes", bytes_seen, 33);
    check("bp_left", exp_q.size(), 0);

    // Two NACKs on byte1 of entry 2
    prep(1, 0);
    pulse_start();
    wait_end("nack2");
    check("nack2_done", done, 1);
    check("nack2_err", err, 0);
    check("nack2_nacks", nack_cnt, 2);
    check("nack2_bytes", bytes_seen, 37);
    check("nack2_left", exp_q.size(), 0);

    // NACK on every address byte: retries exhausted
    prep(2, 0);
    pulse_start();
    wait_end("nackall");
    check("nackall_err", err, 1);
    check("nackall_done", done, 0);
    check("nackall_busy", busy, 0);
    check("nackall_bytes", bytes_seen, 4);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (cmd_valid) n++;
    end
    check("nackall_quiet", n, 0);
    check("nackall_rstn", codec_rstn, 1);

    // Reset while entry 5 waits for its response, then a stray response
    prep(3, 0);
    pulse_start();
    check("err_cleared", err, 0);
    n = 0;
    while (!hold_flag && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached", hold_flag, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_valid", cmd_valid, 0);
    check("rstmid_rstn", codec_rstn, 0);
    @(negedge clk);
    rst = 1'b0;
    release_flag = 1'b1;
    n = 0;
    while (!stray_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_err", err, 0);
    check("rstmid_idle_valid", cmd_valid, 0);
    check("rstmid_idle_rstn", codec_rstn, 0);
    check("rstmid_data", cmd_data, 0);
    prep(0, 0);
    pulse_start();
    check_rstn_low("replay_rstn_low");
    wait_end("replay");
    check("replay_done", done, 1);
    check("replay_bytes", bytes_seen, 33);
    check("replay_log0", log_q[0], {2'b10, 8'h34});
    check("replay_log1", log_q[1], {2'b00, 8'h1E});

`ifdef CODEC_CFG_HOSTWR_EN
    // Host single-register write from DONE
    prep(0, 0);
    exp_q.delete();
    exp_q.push_back({2'b10, 8'h34});
    exp_q.push_back({2'b00, 8'h04});
    exp_q.push_back({2'b01, 8'h79});
    check("host_ready", host_wr_ready, 1);
    host_wr_word = 16'h0479;
    host_wr_valid = 1'b1;
    @(negedge clk);
    host_wr_valid = 1'b0;
    check("host_busy", busy, 1);
    n = 0;
    while (busy && n < BUDGET) begin
      if (!done) n = BUDGET;
      @(negedge clk);
      n++;
    end
    check("host_done_held", (n < BUDGET), 1);
    check("host_done", done, 1);
    check("host_err", err, 0);
    check("host_bytes", bytes_seen, 3);
    check("host_left", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/codec_cfg_seq.md
Name: codec_cfg_seq

Overview:
Power-up and configuration sequencer for the audio codec's control port. It drives the codec hardware reset, waits the power-up time, then writes a fixed register table as 3-byte I2C write transactions through an external byte-level I2C master. It then reports completion so the audio core can start I2S traffic. It sits beside the I2S interface and gates its init/enable.

Parameters:
DEV_ADDR, 7'h1A, codec 7-bit I2C device address
NUM_REGS, 11, number of entries in the config table (last entry = ACTIVE register)
RST_CYCLES, 1000, clk cycles codec_rstn held low
PWR_WAIT_CYCLES, 50000, clk cycles after reset release before the first write
ACT_WAIT_CYCLES, 10000, clk cycles before writing the last (ACTIVE) entry
WR_RETRIES, 3, retries per register write after a NACK

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  pulse; begin full sequence
busy  out  1  sequence in progress
done  out  1  level; table fully written
err  out  1  level; retries exhausted
codec_rstn  out  1  codec hardware reset, active-low
cmd_valid  out  1  byte command to I2C master
cmd_ready  in  1  master accepts command
cmd_start  out  1  generate START before byte
cmd_stop  out  1  generate STOP after byte
cmd_data  out  8  byte to transmit
rsp_valid  in  1  byte finished, 1-cycle pulse
rsp_nack  in  1  qualifies rsp_valid; slave NACKed (master has already issued STOP)

Behaviour:
- Reset values: busy=0, done=0, err=0, codec_rstn=0, cmd_valid=0, cmd_start=0, cmd_stop=0, cmd_data=0. FSM enters IDLE. Counters, retry count and index are cleared.
- States: IDLE, RST_HOLD, PWR_WAIT, LOAD, BYTE0, BYTE1, BYTE2, WAIT_RSP, NEXT, ACT_WAIT, DONE, ERR.
- IDLE/DONE/ERR + start: clear done/err, set busy, drive codec_rstn=0, go to RST_HOLD. start in any other state is ignored.
- RST_HOLD: count RST_CYCLES, then codec_rstn=1 and go to PWR_WAIT. PWR_WAIT: count PWR_WAIT_CYCLES, then idx=0 and go to LOAD.
- Entry format: 16 bits {reg[6:0], data[8:0]}. The write sends byte0={DEV_ADDR,1'b0} with cmd_start=1, byte1={reg,data[8]}, then byte2=data[7:0] with cmd_stop=1.
- Command handshake: cmd_valid/cmd_start/cmd_stop/cmd_data are registered and held stable until the cycle cmd_valid&cmd_ready. cmd_valid drops the next cycle, then the FSM waits for rsp_valid in WAIT_RSP. Only one byte is outstanding at a time.
- ACK: advance to the next byte. After byte2, go to NEXT.
- NACK on any byte: if retry<WR_RETRIES, increment retry and restart at BYTE0 of the same entry. Otherwise go to ERR: err=1, busy=0, codec_rstn stays 1.
- NEXT: clear retry and increment idx. If idx==NUM_REGS-1, go to ACT_WAIT (count ACT_WAIT_CYCLES) then LOAD. If all entries are written, go to DONE: done=1, busy=0.
- Counters: a down-counter of width $clog2(max wait)+1, reloaded on state entry. A count of 0 is treated as 1 cycle.
- rst mid-transaction: cmd_valid drops immediately, codec_rstn=0, and any rsp_valid arriving after reset is ignored (FSM in IDLE).
- rsp_valid outside WAIT_RSP is ignored.

Optional Feature:
CODEC_CFG_HOSTWR_EN: adds ports host_wr_valid(in,1), host_wr_ready(out,1), host_wr_word(in,16).
- With the macro: host_wr_ready=1 only in DONE. On the handshake the FSM latches the word and runs the same BYTE0..BYTE2/retry path, with done held and busy=1 during the write. It returns to DONE on success and goes to ERR on exhaustion. start takes priority over host_wr_valid in the same cycle.
- Without the macro: no ports, and DONE is terminal until start or rst.

Decomposition:
- Package codec_cfg_pkg: the state enum, the CFG_TABLE constant array of NUM_REGS×16 bits, named register-address localparams (LINVOL, RINVOL, ANAPATH, DIGPATH, PWRDN, DAIF, SAMPLING, ACTIVE, RESET), and the entry-field extraction widths.
- Sub-module codec_reg_wr: the 3-byte write engine with retry counter and command/response handshake. Its interface is go, word, busy, ok, fail. The top FSM owns the delays and the table index.

Test Plan:
- Clean sequence with RST_CYCLES=4, PWR_WAIT=8, ACT_WAIT=5 and an always-ACK model -> codec_rstn low for exactly 4 cycles; 33 cmd bytes; first 3 bytes are 8'h34(start), {reg0,d8}, d[7:0](stop); then done=1, busy=0.
- Backpressure with cmd_ready low for 7 cycles per byte -> cmd_valid/cmd_data stable throughout; byte order unchanged.
- NACK on byte1 of entry 2 twice, then ACK -> entry 2 BYTE0 is reissued twice with start=1; done=1 and err=0.
- NACK on every byte0 with WR_RETRIES=3 -> exactly 4 attempts, then err=1, busy=0, no further cmd_valid.
- rst asserted while in WAIT_RSP of entry 5, then a stray rsp_valid -> all outputs at reset values; FSM stays IDLE; a new start replays from entry 0.
- HOSTWR_EN: host_wr_word=16'h0479 in DONE -> bytes 8'h34, 8'h04, 8'h79; busy pulses; done stays 1.
